// File: rtl/arilla_bus_pkg.sv
// Shared types for the arilla bus arbiter: lock FSM states, index type and pointer helper.
package arilla_bus_pkg;

  localparam int DefaultNumMasters = 2;
  localparam int ReadLatency       = 1;

  typedef logic [$clog2(DefaultNumMasters)-1:0] arb_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Rotating increment; wraps to base so the priority build can skip master 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n,
                                           input int unsigned base);
    return (idx + 1 >= n) ? base : idx + 1;
  endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Arilla peripheral bus: the arbiter drives the request side, peripherals answer on data_ptc.
interface arilla_bus_if #(
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0]  address;
  logic                     read;
  logic                     write;
  logic [DataWidth/8-1:0]   byte_enable;
  logic [DataWidth-1:0]     data_ctp;
  logic [DataWidth-1:0]     data_ptc;
  logic                     intercept;

  // Handshake: a request is presented for exactly the cycle read or write is high;
  // there is no ready, and read data returns on data_ptc one cycle later.
  modport master (
    output address, read, write, byte_enable, data_ctp,
    input  data_ptc
  );

  modport slave (
    input  address, read, write, byte_enable, data_ctp,
    output data_ptc, intercept
  );
endinterface

// File: rtl/arilla_rr_picker.sv
// Combinational rotating first-one finder: first set bit of req at or after start.
module arilla_rr_picker #(
  parameter int NumMasters = 2
) (
  input  logic [NumMasters-1:0]         req,
  input  logic [$clog2(NumMasters)-1:0] start,
  output logic [NumMasters-1:0]         gnt,
  output logic [$clog2(NumMasters)-1:0] idx
);

  localparam int IdxW = $clog2(NumMasters);

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NumMasters; k++) begin
      cand = (32'(start) + 32'(k)) % 32'(NumMasters);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter with bounded bus lock sharing one arilla bus between NumMasters.
// Define ARILLA_ARB_PRIORITY_EN to give master 0 fixed priority while unlocked.
module arilla_bus_arbiter
  import arilla_bus_pkg::*;
#(
  parameter int NumMasters    = 2,
  parameter int AddressWidth  = 30,
  parameter int DataWidth     = 32,
  parameter int MaxLockCycles = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  arilla_bus_if.master                      bus_interface,
  input  logic [NumMasters*AddressWidth-1:0] req_address,
  input  logic [NumMasters-1:0]             req_read,
  input  logic [NumMasters-1:0]             req_write,
  input  logic [NumMasters*DataWidth/8-1:0] req_byte_enable,
  input  logic [NumMasters*DataWidth-1:0]   req_data,
  input  logic [NumMasters-1:0]             req_lock,
  output logic [NumMasters-1:0]             gnt,
  output logic [NumMasters-1:0]             rsp_valid,
  output logic [DataWidth-1:0]              rsp_data,
  output lock_state_e                       lock_state
);

  localparam int IdxW = $clog2(NumMasters);
  localparam int BeW  = DataWidth / 8;
  localparam int CntW = $clog2(MaxLockCycles + 1);

`ifdef ARILLA_ARB_PRIORITY_EN
  localparam int unsigned RrBase = 1;
`else
  localparam int unsigned RrBase = 0;
`endif

  lock_state_e             state_q, state_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [NumMasters-1:0]   blocked_q, blocked_d;

  logic [NumMasters-1:0]   req, rr_req, pick_gnt;
  logic [IdxW-1:0]         pick_idx, gnt_idx;
  logic                    prio_win;

  assign req        = req_read | req_write;
  assign lock_state = state_q;

`ifdef ARILLA_ARB_PRIORITY_EN
  assign rr_req   = req & ~NumMasters'(1);
  assign prio_win = req[0];
`else
  assign rr_req   = req;
  assign prio_win = 1'b0;
`endif

  arilla_rr_picker #(.NumMasters(NumMasters)) u_picker (
    .req   (rr_req),
    .start (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  // Grant: a lock owner excludes everyone else, even while it is idle.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          gnt_idx      = owner_q;
        end
      end else if (prio_win) begin
        gnt[0]  = 1'b1;
        gnt_idx = '0;
      end else begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    blocked_d  = blocked_q & req_lock;
    unique case (state_q)
      UNLOCKED: begin
        if (|gnt) begin
          if (req_lock[gnt_idx] && !blocked_q[gnt_idx]) begin
            state_d    = LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = CntW'(1);
          end else if (!prio_win) begin
            rr_ptr_d = IdxW'(wrap_inc(32'(gnt_idx), NumMasters, RrBase));
          end
        end
      end
      LOCKED: begin
        if (!req_lock[owner_q]) begin
          state_d    = UNLOCKED;
          rr_ptr_d   = IdxW'(wrap_inc(32'(owner_q), NumMasters, RrBase));
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CntW'(MaxLockCycles)) begin
          // Forced release: owner must drop req_lock once before it may lock again.
          state_d            = UNLOCKED;
          rr_ptr_d           = IdxW'(wrap_inc(32'(owner_q), NumMasters, RrBase));
          lock_cnt_d         = '0;
          blocked_d[owner_q] = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      owner_q    <= '0;
      rr_ptr_q   <= IdxW'(RrBase);
      lock_cnt_q <= '0;
      blocked_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      blocked_q  <= blocked_d;
    end
  end

  always_comb begin
    bus_interface.address     = '0;
    bus_interface.read        = 1'b0;
    bus_interface.write       = 1'b0;
    bus_interface.byte_enable = '0;
    bus_interface.data_ctp    = '0;
    for (int i = 0; i < NumMasters; i++) begin
      if (gnt[i]) begin
        bus_interface.address     = req_address[i*AddressWidth +: AddressWidth];
        bus_interface.read        = req_read[i];
        bus_interface.write       = req_write[i];
        bus_interface.byte_enable = req_byte_enable[i*BeW +: BeW];
        bus_interface.data_ctp    = req_data[i*DataWidth +: DataWidth];
      end
    end
  end

  // Peripherals answer one cycle after the request, so one tag stage suffices.
  if (ReadLatency == 1) begin : g_rsp
    logic [NumMasters-1:0] rsp_valid_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rsp_valid_q <= '0;
      else     rsp_valid_q <= gnt & req_read;
    end
    assign rsp_valid = rsp_valid_q;
  end else begin : g_rsp_none
    assign rsp_valid = '0;
  end

  assign rsp_data = bus_interface.data_ptc;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed self-checking bench for arilla_bus_arbiter; ARILLA_ARB_PRIORITY_EN selects the priority suite.
module tb_arilla_bus_arbiter;
  import arilla_bus_pkg::*;

`ifdef ARILLA_ARB_PRIORITY_EN
  localparam int NM = 3;
`else
  localparam int NM = 2;
`endif
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int ML = 16;
  localparam int RW = NM + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] req_address;
  logic [NM-1:0]    req_read, req_write, req_lock;
  logic [NM*BW-1:0] req_byte_enable;
  logic [NM*DW-1:0] req_data;
  logic [NM-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_data;
  lock_state_e      lock_state;

  arilla_bus_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  arilla_bus_arbiter #(
    .NumMasters(NM), .AddressWidth(AW), .DataWidth(DW), .MaxLockCycles(ML)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus_interface   (bus),
    .req_address     (req_address),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_byte_enable (req_byte_enable),
    .req_data        (req_data),
    .req_lock        (req_lock),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .lock_state      (lock_state)
  );

  // Peripheral model: read data is a fixed scramble of the address, one cycle later.
  function automatic logic [DW-1:0] periph(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 32'hA5A5_0000;
  endfunction

  assign bus.intercept = 1'b0;
  always @(posedge clk) if (bus.read) bus.data_ptc <= periph(bus.address);

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    req_address = '0; req_read = '0; req_write = '0;
    req_byte_enable = '0; req_data = '0; req_lock = '0;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic lk,
                       input logic [AW-1:0] a, input logic [BW-1:0] be = '1,
                       input logic [DW-1:0] d = '0);
    req_read[m]                = rd;
    req_write[m]               = wr;
    req_lock[m]                = lk;
    req_address[m*AW +: AW]    = a;
    req_byte_enable[m*BW +: BW] = be;
    req_data[m*DW +: DW]       = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One call per clock cycle: checks this cycle's grant/bus, last cycle's response,
  // and queues the response expected one cycle later.
  task automatic cycle_check(input string tag, input logic [NM-1:0] exp_gnt,
                             input lock_state_e exp_ls);
    logic [RW-1:0]  e;
    logic [AW-1:0]  ea;
    logic           er, ew;
    logic [BW-1:0]  eb;
    logic [DW-1:0]  ed;
    #1;
    check({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
    check({tag, " lock_state"}, 64'(lock_state), 64'(exp_ls));
    if (exp_q.size() == 0) begin
      check({tag, " sb depth"}, 64'(exp_q.size()), 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(e[RW-1 -: NM]));
    if (e[RW-1 -: NM] != '0) check({tag, " rsp_data"}, 64'(rsp_data), 64'(e[DW-1:0]));
    ea = '0; er = 1'b0; ew = 1'b0; eb = '0; ed = '0;
    for (int i = 0; i < NM; i++) begin
      if (exp_gnt[i]) begin
        ea = req_address[i*AW +: AW];
        er = req_read[i];
        ew = req_write[i];
        eb = req_byte_enable[i*BW +: BW];
        ed = req_data[i*DW +: DW];
      end
    end
    check({tag, " bus addr"}, 64'(bus.address), 64'(ea));
    check({tag, " bus read"}, 64'(bus.read), 64'(er));
    check({tag, " bus write"}, 64'(bus.write), 64'(ew));
    check({tag, " bus be"}, 64'(bus.byte_enable), 64'(eb));
    check({tag, " bus data"}, 64'(bus.data_ctp), 64'(ed));
    if (er) exp_q.push_back({exp_gnt, periph(ea)});
    else    exp_q.push_back('0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    exp_q.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 1'b0, 30'h10);
    cycle_check("in_reset", '0, UNLOCKED);
    idle_all();
    rst = 1'b0;

`ifdef ARILLA_ARB_PRIORITY_EN
    for (int c = 0; c < 8; c++) begin
      logic [NM-1:0] eg;
      tick();
      idle_all();
      if (c < 3 || c == 6) drive(0, 1'b1, 1'b0, 1'b0, 30'h100);
      if (c < 7) begin
        drive(1, 1'b1, 1'b0, 1'b0, 30'h200);
        drive(2, 1'b1, 1'b0, 1'b0, 30'h300);
      end
      case (c)
        3, 5:    eg = 3'b010;
        4:       eg = 3'b100;
        7:       eg = 3'b000;
        default: eg = 3'b001;
      endcase
      cycle_check($sformatf("prio c%0d", c), eg, UNLOCKED);
    end
    tick();
    idle_all();
    cycle_check("prio drain", '0, UNLOCKED);
`else
    // Both masters read continuously: strict alternation from master 0.
    for (int c = 0; c < 6; c++) begin
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 30'h10);
      drive(1, 1'b1, 1'b0, 1'b0, 30'h20);
      cycle_check($sformatf("rr c%0d", c), (c % 2 == 0) ? 2'b01 : 2'b10, UNLOCKED);
      check($sformatf("rr c%0d addr", c), 64'(bus.address), (c % 2 == 0) ? 64'h10 : 64'h20);
    end
    tick();
    idle_all();
    cycle_check("rr drain", 2'b00, UNLOCKED);

    // Lone write from master 1.
    tick();
    drive(1, 1'b0, 1'b1, 1'b0, 30'h04, 4'b0011, 32'hDEADBEEF);
    cycle_check("wr", 2'b10, UNLOCKED);
    check("wr data", 64'(bus.data_ctp), 64'hDEADBEEF);
    check("wr be", 64'(bus.byte_enable), 64'h3);
    check("wr addr", 64'(bus.address), 64'h4);
    tick();
    idle_all();
    cycle_check("wr after", 2'b00, UNLOCKED);

    // Voluntary lock by master 0 with intermittent reads; master 1 waits.
    for (int l = 0; l < 8; l++) begin
      logic [1:0]  eg;
      lock_state_e es;
      tick();
      drive(0, (l == 0 || l == 2 || l == 4), 1'b0, (l < 5), 30'h30 + 30'(l));
      drive(1, (l < 7), 1'b0, 1'b0, 30'h40);
      case (l)
        0, 2, 4: eg = 2'b01;
        6:       eg = 2'b10;
        default: eg = 2'b00;
      endcase
      es = (l >= 1 && l <= 5) ? LOCKED : UNLOCKED;
      cycle_check($sformatf("lock l%0d", l), eg, es);
    end

    // Lock held past the limit: forced release, then no relock until lock drops.
    for (int f = 0; f < 27; f++) begin
      logic [1:0]  eg;
      lock_state_e es;
      tick();
      idle_all();
      if (f < 24) drive(0, 1'b1, 1'b0, (f != 20), 30'h50);
      if (f < 26) drive(1, 1'b1, 1'b0, 1'b0, 30'h60);
      if (f <= 16) begin
        eg = 2'b01;
        es = (f == 0) ? UNLOCKED : LOCKED;
      end else begin
        case (f)
          17, 19, 21, 25: begin eg = 2'b10; es = UNLOCKED; end
          18, 20, 22:     begin eg = 2'b01; es = UNLOCKED; end
          23:             begin eg = 2'b01; es = LOCKED;   end
          24:             begin eg = 2'b00; es = LOCKED;   end
          default:        begin eg = 2'b00; es = UNLOCKED; end
        endcase
      end
      cycle_check($sformatf("force f%0d", f), eg, es);
    end

    // Reset right after a read grant: the response is dropped.
    tick();
    idle_all();
    drive(0, 1'b1, 1'b0, 1'b0, 30'h70);
    cycle_check("rst pre", 2'b01, UNLOCKED);
    #2;
    rst = 1'b1;
    #1;
    check("rst gnt now", 64'(gnt), 64'h0);
    check("rst bus read now", 64'(bus.read), 64'h0);
    exp_q.delete();
    exp_q.push_back('0);
    idle_all();
    tick();
    cycle_check("rst hold", 2'b00, UNLOCKED);
    rst = 1'b0;
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 30'h11);
    drive(1, 1'b1, 1'b0, 1'b0, 30'h22);
    cycle_check("post rst", 2'b01, UNLOCKED);
    tick();
    idle_all();
    cycle_check("post rst rsp", 2'b00, UNLOCKED);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arilla_bus_arbiter.md
Name: arilla_bus_arbiter

Overview:
- Shares one arilla bus (the master side of arilla_bus_if) between NumMasters requesters, e.g. the core load/store port and the debug module's system-bus access port.
- Arbitration is round-robin, with an optional bounded bus lock for atomic sequences.
- Peripherals respond to reads one cycle after the request. The block tracks which master owns each outstanding read and returns its data with a per-master valid strobe.
- Sits between the masters and every peripheral memory interface on the bus.

Parameters:
- NumMasters, 2, number of requesting masters (≥2).
- AddressWidth, 30, word address width on the bus.
- DataWidth, 32, bus data width; byte-enable width = DataWidth/8.
- MaxLockCycles, 16, maximum consecutive cycles one master may hold the lock.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- bus_interface  arilla_bus_if  -  shared bus, master side (address, read, write, byte_enable, data_ctp driven; data_ptc sampled)
- req_address  input  NumMasters*AddressWidth  per-master word address
- req_read  input  NumMasters  per-master read request
- req_write  input  NumMasters  per-master write request
- req_byte_enable  input  NumMasters*DataWidth/8  per-master byte enables
- req_data  input  NumMasters*DataWidth  per-master write data
- req_lock  input  NumMasters  per-master lock request
- gnt  output  NumMasters  one-hot grant; request accepted this cycle
- rsp_valid  output  NumMasters  read data valid for master i
- rsp_data  output  DataWidth  read data (shared by all masters)

Behaviour:
- Request: req_i = req_read[i] | req_write[i]. A master holds its request and fields stable until gnt[i]. A master must not assert read and write together; if it does, both are passed through unchanged.
- Grant (combinational, same cycle):
  - If a lock owner exists, only the owner can be granted.
  - Otherwise the first requesting master starting at rr_ptr, wrapping modulo NumMasters, is granted.
  - gnt is one-hot or all-zero.
- Bus drive:
  - With a grant: the granted master's address, read, write, byte_enable and data to bus_interface.
  - Without a grant: read=0, write=0, address=0, byte_enable=0, data_ctp=0.
  - intercept is not driven by this block.
- rr_ptr (registered, reset 0): on any grant to master g with no lock owner remaining afterwards, rr_ptr <= (g+1) mod NumMasters.
- Lock FSM states, per the arbiter:
  - UNLOCKED: a grant to g with req_lock[g]=1 -> LOCKED(owner=g), lock_cnt<=1.
  - LOCKED:
    - Stays locked while req_lock[owner]=1. This holds even in idle cycles, where other masters remain ungranted. lock_cnt increments every cycle.
    - req_lock[owner]=0 -> UNLOCKED, rr_ptr<=owner+1.
    - lock_cnt==MaxLockCycles -> forced release: UNLOCKED, rr_ptr<=owner+1, blocked[owner]<=1.
  - blocked[i]: master i may still be granted, but cannot re-acquire the lock until req_lock[i] has been low for ≥1 cycle, which clears blocked[i].
- Response:
  - rsp_valid[i] <= gnt[i] & req_read[i], registered, giving a latency of exactly 1 cycle.
  - rsp_data = bus_interface.data_ptc, combinational, meaningful only when some rsp_valid bit is set.
  - Back-to-back reads from different masters return in grant order, one per cycle, with no bubble.
- Simultaneous events: all masters requesting with none locked -> strict rotation, each master served once per NumMasters grants.
- Reset (asynchronous, any time):
  - gnt=0, rsp_valid=0, rr_ptr=0, UNLOCKED, lock_cnt=0, blocked=0.
  - An outstanding read response in flight is discarded (rsp_valid stays 0).

Optional Feature:
- ARILLA_ARB_PRIORITY_EN defined:
  - When unlocked, master 0 (debug port) wins whenever requesting; round-robin applies among masters 1..N-1 only.
  - An existing lock owner still keeps the bus until release. rr_ptr never points at 0.
- Undefined: pure round-robin as above.

Decomposition:
- Package arilla_bus_pkg:
  - arb_idx_t = logic [$clog2(NumMasters)-1:0].
  - lock_state_e {UNLOCKED, LOCKED}.
  - ReadLatency = 1.
- Sub-module arilla_rr_picker: combinational rotating first-one finder (req vector, start pointer -> one-hot grant plus index), instantiated once.

Test Plan:
- Masters 0,1 both read addr 0x10/0x20 continuously from reset -> gnt 01,10,01,10...; bus address alternates 0x10, 0x20; rsp_valid pulses one cycle after each grant, matching the master.
- Master 1 writes 0xDEADBEEF with be=0b0011 to 0x04 alone -> gnt[1] same cycle; bus write=1, byte_enable=0011, data_ctp=0xDEADBEEF; rsp_valid stays 0.
- Master 0 asserts lock for 5 cycles with intermittent reads while master 1 requests -> gnt[1]=0 throughout the lock; master 1 granted the cycle after req_lock[0] drops.
- Master 0 holds lock for 20 cycles, MaxLockCycles=16 -> forced release at cycle 16; master 1 granted next; master 0 cannot relock until req_lock[0] has been low for ≥1 cycle.
- rst asserted the cycle after a read grant -> rsp_valid stays 0; gnt=0 immediately; after release, first grant goes to master 0.
- With ARILLA_ARB_PRIORITY_EN, masters 0,1,2 requesting -> master 0 granted every cycle; masters 1 and 2 alternate only when master 0 is idle.
